// File: rtl/priority_encoder_sync.sv
// Sequential 8-to-3 priority encoder: synchronises and debounces switch lines,
// then emits the index of the highest active line over a valid/ready handshake.
module priority_encoder_sync #(
  parameter int N_IN          = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in_lines,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [2:0]      out_code,
  output logic            out_multi,
  output logic            out_none
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_IN-1:0]  s1_q, s1_d;
  logic [N_IN-1:0]  s2_q, s2_d;
  logic [N_IN-1:0]  s2_prev_q, s2_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0]  committed_q, committed_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_code_q, out_code_d;
  logic             out_multi_q, out_multi_d;
  logic             out_none_q, out_none_d;
  logic             same, stable, xfer, commit;

  function automatic logic [2:0] msb_index(input logic [N_IN-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < N_IN; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [N_IN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_IN; i++)
      n = n + {3'b000, v[i]};
    return n > 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    s1_d        = in_lines;
    s2_d        = s1_q;
    s2_prev_d   = s2_q;
    same        = (s2_q == s2_prev_q);
    cnt_d       = same ? sat_inc(cnt_q) : '0;
    stable      = (cnt_q == CNT_MAX) && same;
    xfer        = out_valid_q && out_ready;
    // A held payload blocks commits; the debounce above keeps tracking regardless.
    commit      = stable && (s2_q != committed_q) && (!out_valid_q || out_ready);
    committed_d = committed_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_multi_d = out_multi_q;
    out_none_d  = out_none_q;
    if (commit) begin
      committed_d = s2_q;
      out_valid_d = 1'b1;
      out_code_d  = msb_index(s2_q);
      out_multi_d = multi_hot(s2_q);
      out_none_d  = (s2_q == '0);
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s2_prev_q   <= '0;
      cnt_q       <= '0;
      committed_q <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_multi_q <= 1'b0;
      out_none_q  <= 1'b1;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s2_prev_q   <= s2_prev_d;
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_multi_q <= out_multi_d;
      out_none_q  <= out_none_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_multi = out_multi_q;
  assign out_none  = out_none_q;

endmodule

// File: tb/tb_priority_encoder_sync.sv
// Bench for priority_encoder_sync: directed scenarios plus randomized traffic,
// checked against a sample-window reference model.
module tb_priority_encoder_sync;
  localparam int STABLE_CYCLES = 4;
  localparam int LAT = STABLE_CYCLES + 3;
  localparam int WIN = STABLE_CYCLES + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_lines;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic       out_multi;
  logic       out_none;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  priority_encoder_sync #(.N_IN(8), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk(clk), .reset(reset), .in_lines(in_lines), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_multi(out_multi), .out_none(out_none)
  );

  // Reference model: hist[0] is the newest sampled input, hist[1] the synchronised value.
  logic [7:0] hist [WIN];
  int         nsamp;
  logic       m_valid, m_multi, m_none, m_stable, m_commit;
  logic [2:0] m_code;
  logic [7:0] m_committed;

  function automatic logic [2:0] top_line(input logic [7:0] v);
    for (int i = 7; i >= 0; i--)
      if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always_comb begin
    m_stable = (nsamp >= WIN);
    for (int i = 2; i < WIN; i++)
      if (hist[i] != hist[1]) m_stable = 1'b0;
    m_commit = m_stable && (hist[1] != m_committed) && (!m_valid || out_ready);
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) hist[i] <= 8'h00;
      nsamp       <= 3;
      m_valid     <= 1'b0;
      m_code      <= 3'd0;
      m_multi     <= 1'b0;
      m_none      <= 1'b1;
      m_committed <= 8'h00;
    end else begin
      for (int i = WIN - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= in_lines;
      nsamp   <= (nsamp < WIN) ? nsamp + 1 : WIN;
      if (m_commit) begin
        m_committed <= hist[1];
        m_valid     <= 1'b1;
        m_code      <= top_line(hist[1]);
        m_multi     <= ($countones(hist[1]) > 1);
        m_none      <= (hist[1] == 8'h00);
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1; in_lines = 8'hFF; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, out_code, out_none} !== {1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL reset_state: got v=%b c=%0d n=%b want v=0 c=0 n=1", out_valid, out_code, out_none);
    end
    reset = 1'b0;
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (j == LAT)) begin
        bad++; $display("FAIL reset_latency edge %0d: got v=%b want v=%b", j, out_valid, (j == LAT));
      end
    end
    total++;
    if ({out_code, out_multi, out_none} !== {3'd7, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_first_tx: got c=%0d m=%b n=%b want c=7 m=1 n=0", out_code, out_multi, out_none);
    end
  endtask

  task automatic test_single_line;
    int ntx;
    in_lines = 8'h00;
    repeat (10) @(negedge clk);
    in_lines = 8'h20;
    ntx = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (out_valid) ntx++;
      total++;
      if ({out_valid, out_code, out_multi, out_none} !== {m_valid, m_code, m_multi, m_none}) begin
        bad++; $display("FAIL single_model edge %0d: got %b%b%b%b want %b%b%b%b", j, out_valid, out_code, out_multi, out_none, m_valid, m_code, m_multi, m_none);
      end
      if (j == LAT) begin
        total++;
        if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
          bad++; $display("FAIL single_tx: got v=%b c=%0d m=%b n=%b want v=1 c=5 m=0 n=0", out_valid, out_code, out_multi, out_none);
        end
      end
    end
    total++;
    if (ntx != 1) begin
      bad++; $display("FAIL single_count: got %0d transactions want 1", ntx);
    end
  endtask

  task automatic test_priority_release;
    int ntx;
    in_lines = 8'h82;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == LAT) begin
        total++;
        if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
          bad++; $display("FAIL prio_tx: got v=%b c=%0d m=%b n=%b want v=1 c=7 m=1 n=0", out_valid, out_code, out_multi, out_none);
        end
      end
    end
    in_lines = 8'h00;
    ntx = 0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (out_valid) ntx++;
      if (j == LAT) begin
        total++;
        if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
          bad++; $display("FAIL release_tx: got v=%b c=%0d m=%b n=%b want v=1 c=0 m=0 n=1", out_valid, out_code, out_multi, out_none);
        end
      end
    end
    total++;
    if (ntx != 1) begin
      bad++; $display("FAIL release_count: got %0d transactions want 1", ntx);
    end
  endtask

  task automatic test_glitch;
    int nv;
    nv = 0;
    in_lines = 8'h08;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    in_lines = 8'h00;
    repeat (14) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    total++;
    if (nv != 0) begin
      bad++; $display("FAIL glitch: got %0d valid cycles want 0", nv);
    end
  endtask

  task automatic test_backpressure;
    int nbad;
    out_ready = 1'b0;
    in_lines = 8'h01;
    repeat (LAT) @(negedge clk);
    total++;
    if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL bp_first: got v=%b c=%0d m=%b n=%b want v=1 c=0 m=0 n=0", out_valid, out_code, out_multi, out_none);
    end
    nbad = 0;
    in_lines = 8'h04;
    repeat (10) begin
      @(negedge clk);
      if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd0, 1'b0, 1'b0}) nbad++;
    end
    in_lines = 8'h10;
    repeat (10) begin
      @(negedge clk);
      if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd0, 1'b0, 1'b0}) nbad++;
    end
    total++;
    if (nbad != 0) begin
      bad++; $display("FAIL bp_hold: got %0d cycles with altered payload want 0", nbad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_code, out_multi, out_none} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
      bad++; $display("FAIL bp_b2b: got v=%b c=%0d m=%b n=%b want v=1 c=4 m=0 n=0", out_valid, out_code, out_multi, out_none);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: got v=%b want v=0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_lines = 8'h40;
    repeat (LAT + 2) @(negedge clk);
    total++;
    if ({out_valid, out_code} !== {1'b1, 3'd6}) begin
      bad++; $display("FAIL mid_pre: got v=%b c=%0d want v=1 c=6", out_valid, out_code);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_code, out_none} !== {1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL mid_reset: got v=%b c=%0d n=%b want v=0 c=0 n=1", out_valid, out_code, out_none);
    end
    reset = 1'b0;
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      total++;
      if (out_valid !== (j == LAT)) begin
        bad++; $display("FAIL mid_latency edge %0d: got v=%b want v=%b", j, out_valid, (j == LAT));
      end
    end
    total++;
    if ({out_code, out_multi, out_none} !== {3'd6, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mid_reemit: got c=%0d m=%b n=%b want c=6 m=0 n=0", out_code, out_multi, out_none);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] vals [6];
    int hold;
    vals[0] = 8'h00; vals[1] = 8'h81; vals[2] = 8'h02; vals[3] = 8'h3C; vals[4] = 8'h40; vals[5] = 8'hFF;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_code, out_multi, out_none} !== {m_valid, m_code, m_multi, m_none}) begin
        bad++; $display("FAIL random cycle %0d: got %b%b%b%b want %b%b%b%b", c, out_valid, out_code, out_multi, out_none, m_valid, m_code, m_multi, m_none);
      end
      if (hold == 0) begin
        in_lines = vals[$urandom_range(0, 5)];
        hold = $urandom_range(1, 9);
      end
      hold--;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    reset = 1'b1; in_lines = 8'h00; out_ready = 1'b1;
    test_reset();
    test_single_line();
    test_priority_release();
    test_glitch();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
